// File: rtl/snitch_perf_sampler.sv
// Performance-counter sampler: sweeps the masked counter registers over the register
// bus and streams timestamped samples out through a small valid/ready FIFO.

package snitch_perf_sampler_pkg;
    typedef struct packed {
        logic [47:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module snitch_perf_sampler #(
    parameter int unsigned          AddrWidth     = 48,
    parameter int unsigned          DataWidth     = 64,
    parameter int unsigned          NumCounters   = 16,
    parameter logic [AddrWidth-1:0] CounterBase   = '0,
    parameter int unsigned          CounterStride = 8,
    parameter int unsigned          FifoDepth     = 4,
    parameter type                  reg_req_t     = snitch_perf_sampler_pkg::reg_req_t,
    parameter type                  reg_rsp_t     = snitch_perf_sampler_pkg::reg_rsp_t,
    localparam int unsigned         IdxWidth      = $clog2(NumCounters)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_enable_i,
    input  logic [31:0]            cfg_period_i,
    input  logic [NumCounters-1:0] cfg_mask_i,
    input  logic                   trigger_i,
    output reg_req_t               reg_req_o,
    input  reg_rsp_t               reg_rsp_i,
    output logic                   sample_valid_o,
    input  logic                   sample_ready_i,
    output logic [IdxWidth-1:0]    sample_idx_o,
    output logic [47:0]            sample_data_o,
    output logic [31:0]            sample_ts_o,
    output logic                   sample_err_o,
    output logic                   busy_o,
    output logic [15:0]            overrun_o
);

    typedef enum logic [1:0] {IDLE, SCAN, REQ} state_e;

    localparam int unsigned PtrWidth    = $clog2(FifoDepth);
    localparam int unsigned SampleWidth = IdxWidth + 48 + 32 + 1;

    state_e                 state_reg, state_next;
    logic [31:0]            ts_reg, sweep_ts_reg, timer_reg;
    logic [NumCounters-1:0] pending_reg;
    logic [IdxWidth-1:0]    idx_reg;
    logic [AddrWidth-1:0]   addr_reg;
    logic [15:0]            overrun_reg;

    logic                   timer_on, timer_expire, start, busy;
    logic                   scan_hit;
    logic [IdxWidth-1:0]    scan_idx;
    logic                   latch_sweep, issue_req, req_done;

    logic [DataWidth-1:0]   rdata;
    logic                   unused_rdata_hi;

    logic [SampleWidth-1:0] fifo_mem [FifoDepth];
    logic [PtrWidth-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [PtrWidth:0]      count_reg;
    logic                   fifo_full, fifo_empty, push, pop;
    logic [SampleWidth-1:0] push_data, head;

    assign rdata           = reg_rsp_i.rdata;
    assign unused_rdata_hi = ^rdata[DataWidth-1:48];

    // Timer expires when it reaches zero, giving one expiry every cfg_period_i cycles.
    assign timer_on     = cfg_enable_i && (cfg_period_i != '0);
    assign timer_expire = timer_on && (timer_reg == '0);
    assign start        = timer_expire || trigger_i;
    assign busy         = (state_reg != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_reg      <= '0;
            timer_reg   <= cfg_period_i - 32'd1;
            overrun_reg <= '0;
        end else begin
            ts_reg <= ts_reg + 32'd1;
            if (!timer_on || timer_expire) begin
                timer_reg <= cfg_period_i - 32'd1;
            end else begin
                timer_reg <= timer_reg - 32'd1;
            end
            if (timer_expire && busy && (overrun_reg != 16'hFFFF)) begin
                overrun_reg <= overrun_reg + 16'd1;
            end
        end
    end

    // Lowest pending counter wins, so samples leave in ascending index order.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        for (int i = NumCounters - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                scan_hit = 1'b1;
                scan_idx = IdxWidth'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        latch_sweep = 1'b0;
        issue_req   = 1'b0;
        req_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    latch_sweep = 1'b1;
                    state_next  = SCAN;
                end
            end
            SCAN: begin
                if (!scan_hit) begin
                    state_next = IDLE;
                end else if (!fifo_full) begin
                    issue_req  = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (reg_rsp_i.ready) begin
                    req_done   = 1'b1;
                    state_next = SCAN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_reg  <= '0;
            sweep_ts_reg <= '0;
            idx_reg      <= '0;
            addr_reg     <= '0;
        end else begin
            if (latch_sweep) begin
                pending_reg  <= cfg_mask_i;
                sweep_ts_reg <= ts_reg;
            end else if (req_done) begin
                pending_reg[idx_reg] <= 1'b0;
            end
            if (issue_req) begin
                idx_reg  <= scan_idx;
                addr_reg <= CounterBase + AddrWidth'(scan_idx) * AddrWidth'(CounterStride);
            end
        end
    end

    // Read-only initiator: write, wdata and wstrb stay tied to zero.
    always_comb begin
        reg_req_o       = '0;
        reg_req_o.addr  = addr_reg;
        reg_req_o.valid = (state_reg == REQ);
    end

    assign fifo_full  = (count_reg == (PtrWidth + 1)'(FifoDepth));
    assign fifo_empty = (count_reg == '0);
    assign push       = req_done;
    assign pop        = !fifo_empty && sample_ready_i;
    assign push_data  = {idx_reg, (reg_rsp_i.error ? 48'h0 : rdata[47:0]),
                         sweep_ts_reg, reg_rsp_i.error};

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Fields read as zero whenever no sample is offered.
    assign head           = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
    assign sample_valid_o = !fifo_empty;
    assign {sample_idx_o, sample_data_o, sample_ts_o, sample_err_o} = head;
    assign busy_o         = busy;
    assign overrun_o      = overrun_reg;

endmodule

// File: tb/tb_snitch_perf_sampler.sv
// Scoreboard bench for snitch_perf_sampler: a bus responder predicts each sample and a
// stream monitor compares what the sampler emits.

module tb_snitch_perf_sampler;
    import snitch_perf_sampler_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, cfg_enable_i, trigger_i, sample_ready_i;
    logic [31:0] cfg_period_i;
    logic [15:0] cfg_mask_i;
    reg_req_t    reg_req_o;
    reg_rsp_t    reg_rsp_i;
    logic        sample_valid_o, sample_err_o, busy_o;
    logic [3:0]  sample_idx_o;
    logic [47:0] sample_data_o;
    logic [31:0] sample_ts_o;
    logic [15:0] overrun_o;

    snitch_perf_sampler dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .cfg_enable_i   (cfg_enable_i),
        .cfg_period_i   (cfg_period_i),
        .cfg_mask_i     (cfg_mask_i),
        .trigger_i      (trigger_i),
        .reg_req_o      (reg_req_o),
        .reg_rsp_i      (reg_rsp_i),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .sample_idx_o   (sample_idx_o),
        .sample_data_o  (sample_data_o),
        .sample_ts_o    (sample_ts_o),
        .sample_err_o   (sample_err_o),
        .busy_o         (busy_o),
        .overrun_o      (overrun_o)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [47:0] counter_val [16];
    int unsigned delay_cfg [16];
    logic [15:0] err_mask = '0;
    logic [15:0] exp_pend = '0;
    logic [31:0] exp_ts = '0;
    logic [31:0] tb_ts = '0;
    bit          bus_chk = 1'b1;
    bit          sb_en = 1'b1;
    int          resp_count = 0;
    int          pop_count = 0;
    int          busy_cycles = 0;
    logic [84:0] sb_q [$];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [15:0] m);
        for (int i = 0; i < 16; i++) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (rst_i) tb_ts <= '0;
        else       tb_ts <= tb_ts + 32'd1;
    end

    always @(negedge clk) begin
        if (busy_o) busy_cycles++;
    end

    // Bus responder: predicts the request order from the programmed mask.
    initial begin : responder
        bit          in_txn;
        int unsigned wait_left;
        logic [47:0] hold_addr;
        int          idx;
        in_txn    = 1'b0;
        wait_left = 0;
        hold_addr = '0;
        idx       = 0;
        reg_rsp_i = '0;
        forever begin
            @(posedge clk);
            #1;
            reg_rsp_i = '0;
            if (!rst_i && reg_req_o.valid) begin
                if (!in_txn) begin
                    in_txn    = 1'b1;
                    hold_addr = reg_req_o.addr;
                    if (bus_chk) begin
                        idx = lowest(exp_pend);
                        if (idx < 0) begin
                            check_eq("spurious_req", 128'(reg_req_o.valid), 128'(1'b0));
                            idx = 0;
                        end else begin
                            check_eq("req_addr", 128'({reg_req_o.write, reg_req_o.wstrb, reg_req_o.wdata, reg_req_o.addr}),
                                     128'(idx * 8));
                        end
                    end else begin
                        idx = int'(reg_req_o.addr[6:3]);
                    end
                    wait_left = delay_cfg[idx];
                end else begin
                    check_eq("addr_hold", 128'(reg_req_o.addr), 128'(hold_addr));
                end
                if (wait_left == 0) begin
                    reg_rsp_i.ready = 1'b1;
                    reg_rsp_i.error = err_mask[idx];
                    reg_rsp_i.rdata = {16'hBEEF, counter_val[idx]};
                    resp_count++;
                    if (bus_chk) begin
                        exp_pend[idx] = 1'b0;
                        sb_q.push_back({4'(idx), (err_mask[idx] ? 48'h0 : counter_val[idx]), exp_ts, err_mask[idx]});
                    end
                end else begin
                    wait_left--;
                end
            end else begin
                in_txn = 1'b0;
            end
        end
    end

    // Stream monitor: one comparison per accepted sample.
    initial begin : monitor
        logic [84:0] got, want;
        forever begin
            @(negedge clk);
            if (!rst_i && sample_valid_o && sample_ready_i) begin
                pop_count++;
                if (sb_en) begin
                    got = {sample_idx_o, sample_data_o, sample_ts_o, sample_err_o};
                    if (sb_q.size() == 0) begin
                        check_eq("sample_extra", 128'(sample_valid_o), 128'(1'b0));
                    end else begin
                        want = sb_q.pop_front();
                        check_eq("sample", 128'(got), 128'(want));
                        $display("sample idx=%0d data=%h ts=%0d err=%0b", sample_idx_o, sample_data_o,
                                 sample_ts_o, sample_err_o);
                    end
                end
            end
        end
    end

    task automatic trigger_sweep(input logic [15:0] mask);
        cfg_mask_i = mask;
        exp_pend   = mask;
        exp_ts     = tb_ts;
        trigger_i  = 1'b1;
        tick();
        trigger_i  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while ((busy_o || sample_valid_o) && k < budget) begin
            tick();
            k++;
        end
        check_eq({tag, "_idle"}, 128'({busy_o, sample_valid_o}), 128'(2'b00));
        check_eq({tag, "_sb_empty"}, 128'(sb_q.size()), 128'(0));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base_busy, base_resp, base_pop;
        for (int i = 0; i < 16; i++) begin
            counter_val[i] = 48'h1000 + 48'(i);
            delay_cfg[i]   = 0;
        end
        counter_val[0] = 48'h11;
        counter_val[2] = 48'h22;
        rst_i = 1'b1; cfg_enable_i = 1'b0; cfg_period_i = '0; cfg_mask_i = '0;
        trigger_i = 1'b0; sample_ready_i = 1'b1;
        tick(3);
        check_eq("rst_req", 128'({reg_req_o.valid, reg_req_o.addr}), 128'(0));
        check_eq("rst_sample", 128'({sample_valid_o, sample_idx_o, sample_data_o, sample_ts_o, sample_err_o}), 128'(0));
        check_eq("rst_status", 128'({busy_o, overrun_o}), 128'(0));
        rst_i = 1'b0;
        tick(2);

        // Two-counter sweep, mid-sweep mask change and re-trigger ignored.
        base_busy = busy_cycles; base_resp = resp_count; base_pop = pop_count;
        trigger_sweep(16'h0005);
        cfg_mask_i = 16'hFFFF;
        check_eq("t1_start_plus1", 128'({busy_o, reg_req_o.valid}), 128'(2'b10));
        tick();
        check_eq("t1_start_plus2", 128'({busy_o, reg_req_o.valid, reg_req_o.addr}), 128'({2'b11, 48'h0}));
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
        wait_idle("t1", 50);
        check_eq("t1_busy_len", 128'(busy_cycles - base_busy), 128'(5));
        check_eq("t1_resp", 128'(resp_count - base_resp), 128'(2));
        check_eq("t1_pop", 128'(pop_count - base_pop), 128'(2));
        check_eq("t1_overrun", 128'(overrun_o), 128'(0));

        // Slow bus on counter 2.
        delay_cfg[2] = 3;
        base_busy = busy_cycles; base_resp = resp_count; base_pop = pop_count;
        trigger_sweep(16'h0005);
        wait_idle("t2", 50);
        check_eq("t2_busy_len", 128'(busy_cycles - base_busy), 128'(8));
        check_eq("t2_resp", 128'(resp_count - base_resp), 128'(2));
        check_eq("t2_pop", 128'(pop_count - base_pop), 128'(2));
        delay_cfg[2] = 0;

        // Output backpressure stalls the sweep once the FIFO is full.
        sample_ready_i = 1'b0;
        base_resp = resp_count; base_pop = pop_count;
        trigger_sweep(16'hFFFF);
        tick(40);
        check_eq("t3_reads_stalled", 128'(resp_count - base_resp), 128'(4));
        check_eq("t3_stall_state", 128'({busy_o, reg_req_o.valid, sample_valid_o}), 128'(3'b101));
        sample_ready_i = 1'b1;
        wait_idle("t3", 200);
        check_eq("t3_drained", 128'(pop_count - base_pop), 128'(16));

        // Bus error on counter 3.
        err_mask = 16'h0008;
        trigger_sweep(16'h001C);
        wait_idle("t4", 50);
        err_mask = '0;

        // Periodic sweeps with overruns.
        bus_chk = 1'b0; sb_en = 1'b0;
        cfg_mask_i = 16'hFFFF; cfg_period_i = 32'd5;
        tick(2);
        base_resp = resp_count;
        cfg_enable_i = 1'b1;
        tick(60);
        cfg_enable_i = 1'b0;
        check_eq("t5_overrun", 128'(overrun_o), 128'(10));
        wait_idle("t5", 100);
        tick(20);
        check_eq("t5_no_restart", 128'({busy_o, overrun_o}), 128'({1'b0, 16'd10}));
        check_eq("t5_reads", 128'(resp_count - base_resp), 128'(32));
        bus_chk = 1'b1; sb_en = 1'b1;

        // Reset while a read is waiting on the bus.
        sample_ready_i = 1'b0;
        delay_cfg[1] = 20;
        trigger_sweep(16'h0003);
        tick(8);
        check_eq("t6_pre_reset", 128'({reg_req_o.valid, sample_valid_o}), 128'(2'b11));
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_eq("t6_post_reset", 128'({reg_req_o.valid, sample_valid_o, busy_o, overrun_o}), 128'(0));
        sb_q.delete();
        exp_pend = '0;
        delay_cfg[1] = 0;
        sample_ready_i = 1'b1;
        tick(2);
        base_busy = busy_cycles; base_pop = pop_count;
        trigger_sweep(16'h0005);
        wait_idle("t6", 50);
        check_eq("t6_busy_len", 128'(busy_cycles - base_busy), 128'(5));
        check_eq("t6_pop", 128'(pop_count - base_pop), 128'(2));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
